// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage floating-point multiplier (bfloat16 at defaults), subnormals flushed, RNE/RTZ rounding.
// Optional macro FP_MUL_PIPE_STICKY_EN adds clr_flags and sticky_flags {underflow,overflow,inexact}.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] opA,
  input  logic [W-1:0] opB,
  input  logic         rnd,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         underflow,
  output logic         overflow,
  output logic         inexact
`ifdef FP_MUL_PIPE_STICKY_EN
  ,
  input  logic         clr_flags,
  output logic [2:0]   sticky_flags
`endif
);

  localparam int EW      = EXP_W + 2;
  localparam int PW      = 2 * MAN_W + 2;
  localparam int SW      = MAN_W + 2;
  localparam int BIAS    = 2 ** (EXP_W - 1) - 1;
  localparam int EXP_MAX = 2 ** EXP_W - 1;

  localparam logic [1:0] KIND_NUM  = 2'd0;
  localparam logic [1:0] KIND_ZERO = 2'd1;
  localparam logic [1:0] KIND_INF  = 2'd2;
  localparam logic [1:0] KIND_NAN  = 2'd3;

  // One global advance: the whole pipe moves only when the output slot can take a result.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = reset || adv;

  logic           s1_valid, s2_valid, s3_valid;
  logic [W-1:0]   s1_a, s1_b;
  logic           s1_rnd;
  logic           s2_sign, s2_rnd;
  logic [1:0]     s2_kind;
  logic [EW-1:0]  s2_exp;
  logic [MAN_W:0] s2_ma, s2_mb;
  logic           s3_sign, s3_rnd;
  logic [1:0]     s3_kind;
  logic [EW-1:0]  s3_exp;
  logic [PW-1:0]  s3_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s1_a   <= opA;
      s1_b   <= opB;
      s1_rnd <= rnd;
    end
  end

  // S1: unpack, classify, sign and biased exponent sum
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [1:0]       kind1;
  logic [EW-1:0]    exp1;

  assign ea     = s1_a[W-2:MAN_W];
  assign eb     = s1_b[W-2:MAN_W];
  assign ma     = s1_a[MAN_W-1:0];
  assign mb     = s1_b[MAN_W-1:0];
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == '1) && (ma == '0);
  assign inf_b  = (eb == '1) && (mb == '0);
  assign nan_a  = (ea == '1) && (ma != '0);
  assign nan_b  = (eb == '1) && (mb != '0);
  assign exp1   = EW'(ea) + EW'(eb) - EW'(BIAS);

  always_comb begin
    kind1 = KIND_NUM;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
      kind1 = KIND_NAN;
    else if (inf_a || inf_b)
      kind1 = KIND_INF;
    else if (zero_a || zero_b)
      kind1 = KIND_ZERO;
  end

  always_ff @(posedge clk) begin
    if (adv && s1_valid) begin
      s2_sign <= s1_a[W-1] ^ s1_b[W-1];
      s2_kind <= kind1;
      s2_exp  <= exp1;
      s2_ma   <= {1'b1, ma};
      s2_mb   <= {1'b1, mb};
      s2_rnd  <= s1_rnd;
    end
  end

  // S2: significand multiply
  always_ff @(posedge clk) begin
    if (adv && s2_valid) begin
      s3_sign <= s2_sign;
      s3_kind <= s2_kind;
      s3_exp  <= s2_exp;
      s3_prod <= PW'(s2_ma) * PW'(s2_mb);
      s3_rnd  <= s2_rnd;
    end
  end

  // S3: product lies in [1,4), so at most one right shift normalizes it
  logic             top, guard, sticky, inc, ovf, unf;
  logic [PW-1:0]    norm;
  logic [MAN_W:0]   sig;
  logic [SW-1:0]    sig_r;
  logic [EW-1:0]    exp_n;
  logic [MAN_W-1:0] man_f;

  assign top    = s3_prod[PW-1];
  assign norm   = top ? s3_prod : (s3_prod << 1);
  assign sig    = norm[PW-1:MAN_W+1];
  assign guard  = norm[MAN_W];
  assign sticky = |norm[MAN_W-1:0];
  assign inc    = !s3_rnd && guard && (sticky || sig[0]);
  assign sig_r  = {1'b0, sig} + SW'(inc);
  assign exp_n  = s3_exp + EW'(top) + EW'(sig_r[SW-1]);
  assign man_f  = sig_r[SW-1] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
  assign ovf    = !exp_n[EW-1] && (exp_n >= EW'(EXP_MAX));
  assign unf    = exp_n[EW-1] || (exp_n == '0);

  logic [W-1:0] res_p;
  logic         res_uf, res_of, res_ix;

  always_comb begin
    res_p  = '0;
    res_uf = 1'b0;
    res_of = 1'b0;
    res_ix = 1'b0;
    case (s3_kind)
      KIND_NAN:  res_p = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      KIND_INF:  res_p = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      KIND_ZERO: res_p = {s3_sign, {(W-1){1'b0}}};
      default: begin
        if (ovf) begin
          res_p  = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          res_of = 1'b1;
          res_ix = 1'b1;
        end else if (unf) begin
          res_p  = {s3_sign, {(W-1){1'b0}}};
          res_uf = 1'b1;
          res_ix = 1'b1;
        end else begin
          res_p  = {s3_sign, exp_n[EXP_W-1:0], man_f};
          res_ix = guard || sticky;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      product   <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      inexact   <= 1'b0;
    end else if (adv) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        product   <= res_p;
        underflow <= res_uf;
        overflow  <= res_of;
        inexact   <= res_ix;
      end
    end
  end

`ifdef FP_MUL_PIPE_STICKY_EN
  logic deliver;
  assign deliver = out_valid && out_ready;

  // A clear coinciding with a delivery keeps only that delivery's flags.
  always_ff @(posedge clk) begin
    if (reset)
      sticky_flags <= 3'b000;
    else if (clr_flags)
      sticky_flags <= deliver ? {underflow, overflow, inexact} : 3'b000;
    else if (deliver)
      sticky_flags <= sticky_flags | {underflow, overflow, inexact};
  end
`endif

endmodule
